// File: rtl/trapez_pkg.sv
// Shared types and constants for the trapezoidal pulse sequencer.
// Holds the FSM state encoding, datapath widths and the configuration
// legality check used by the shadow-register block.
package trapez_pkg;

  localparam int CONST_W = 16;
  localparam int DATA_W  = 16;
  localparam int CNT_W   = 16;
  localparam int MAX_KL  = 60;

  localparam logic [CNT_W-1:0]         CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]         CNT_MAX  = {CNT_W{1'b1}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FLAT = 2'd2,
    TAIL = 2'd3
  } trapez_state_t;

  // k must be non-zero, l strictly larger than k, and k+l must fit the delay line
  function automatic logic cfg_legal(input logic [CONST_W-1:0] k,
                                     input logic [CONST_W-1:0] l);
    logic [CONST_W:0] sum_s;
    sum_s     = {1'b0, k} + {1'b0, l};
    cfg_legal = (k != {CONST_W{1'b0}}) && (l > k) &&
                (sum_s <= (CONST_W+1)'(MAX_KL));
  endfunction

endpackage

// File: rtl/trapez_cfg_shadow.sv
// Staged -> active constant registers for the shaper.
// A write is only honoured while cfg_en is high; an illegal k/l pair keeps
// the active constants and raises the sticky cfg_err flag.
module trapez_cfg_shadow
  import trapez_pkg::*;
(
  input  logic               clk,
  input  logic               reset_mult,
  input  logic               cfg_wr,
  input  logic               cfg_en,
  input  logic [CONST_W-1:0] cfg_k,
  input  logic [CONST_W-1:0] cfg_l,
  input  logic [CONST_W-1:0] cfg_m1,
  input  logic [CONST_W-1:0] cfg_m2,
  output logic [CONST_W-1:0] k_act,
  output logic [CONST_W-1:0] l_act,
  output logic [CONST_W-1:0] m1_act,
  output logic [CONST_W-1:0] m2_act,
  output logic               cfg_err
);

  logic [CONST_W-1:0] k_r, l_r, m1_r, m2_r;
  logic               cfg_err_r;
  logic               wr_s;
  logic               legal_s;

  assign wr_s    = cfg_wr & cfg_en;
  assign legal_s = cfg_legal(cfg_k, cfg_l);

  // Active constant registers and sticky rejection flag
  always_ff @(posedge clk or negedge reset_mult) begin
    if (!reset_mult) begin
      k_r       <= {CONST_W{1'b0}};
      l_r       <= {CONST_W{1'b0}};
      m1_r      <= {CONST_W{1'b0}};
      m2_r      <= {CONST_W{1'b0}};
      cfg_err_r <= 1'b0;
    end else if (wr_s && legal_s) begin
      k_r       <= cfg_k;
      l_r       <= cfg_l;
      m1_r      <= cfg_m1;
      m2_r      <= cfg_m2;
      cfg_err_r <= 1'b0;
    end else if (wr_s) begin
      cfg_err_r <= 1'b1;
    end else begin
      cfg_err_r <= cfg_err_r;
    end
  end

  assign k_act   = k_r;
  assign l_act   = l_r;
  assign m1_act  = m1_r;
  assign m2_act  = m2_r;
  assign cfg_err = cfg_err_r;

endmodule

// File: rtl/trapez_pulse_sequencer.sv
// Sequences one trapezoidal-shaper pass per trigger: opens pulse_time,
// times rise / flat-top / fall from the trigger, captures the flat-top
// energy and flags pile-up. Optional build macro PEAK_SEARCH_EN replaces the
// midpoint sample with the signed maximum over the whole flat top.
module trapez_pulse_sequencer
  import trapez_pkg::*;
#(
  parameter int PIPE_LAT = 6
) (
  input  logic                     clk,
  input  logic                     reset_mult,
  input  logic                     trigger,
  input  logic                     end_impuls,
  input  logic                     cfg_wr,
  input  logic [CONST_W-1:0]       cfg_k,
  input  logic [CONST_W-1:0]       cfg_l,
  input  logic [CONST_W-1:0]       cfg_m1,
  input  logic [CONST_W-1:0]       cfg_m2,
  input  logic signed [DATA_W-1:0] shaper_data,
  output logic [CONST_W-1:0]       k_trapez,
  output logic [CONST_W-1:0]       l_trapez,
  output logic [CONST_W-1:0]       M1_trapez,
  output logic [CONST_W-1:0]       M2_trapez,
  output logic                     pulse_time,
  output logic                     busy,
  output logic signed [DATA_W-1:0] energy,
  output logic                     energy_valid,
  output logic                     pileup,
  output logic                     cfg_err
);

  localparam logic [CNT_W-1:0] PIPE_LAT_C = CNT_W'(PIPE_LAT);

  trapez_state_t             state_r, state_nxt_s;
  logic [CNT_W-1:0]          cnt_r;
  logic [CONST_W-1:0]        run_k_r, run_l_r;
  logic [CONST_W-1:0]        k_act_s, l_act_s;
  logic [CONST_W:0]          sum_kl_s;
  logic [CNT_W-1:0]          run_end_s, flat_end_s, tail_end_s;
  logic                      trig_ok_s, pileup_s, done_s;
  logic                      pulse_time_r, busy_r, energy_valid_r, pileup_r;
  logic signed [DATA_W-1:0]  energy_r, energy_nxt_s;

  trapez_cfg_shadow u_cfg_shadow (
    .clk        (clk),
    .reset_mult (reset_mult),
    .cfg_wr     (cfg_wr),
    .cfg_en     (state_r == IDLE),
    .cfg_k      (cfg_k),
    .cfg_l      (cfg_l),
    .cfg_m1     (cfg_m1),
    .cfg_m2     (cfg_m2),
    .k_act      (k_act_s),
    .l_act      (l_act_s),
    .m1_act     (M1_trapez),
    .m2_act     (M2_trapez),
    .cfg_err    (cfg_err)
  );

  // Never-configured constants (k==0) make a trigger meaningless
  assign trig_ok_s = trigger && (state_r == IDLE) && (k_act_s != {CONST_W{1'b0}});

  // Phase boundaries use the constants latched at trigger, so a config
  // write in the same cycle as the trigger only affects the next pulse
  assign sum_kl_s   = {1'b0, run_k_r} + {1'b0, run_l_r};
  assign run_end_s  = PIPE_LAT_C + CNT_W'(run_k_r) - CNT_ONE;
  assign flat_end_s = PIPE_LAT_C + CNT_W'(run_l_r) - CNT_ONE;
  assign tail_end_s = PIPE_LAT_C + CNT_W'(sum_kl_s) - CNT_ONE;

  // State register
  always_ff @(posedge clk or negedge reset_mult) begin
    if (!reset_mult) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: pile-up beats abort, abort beats normal sequencing
  always_comb begin
    state_nxt_s = state_r;
    pileup_s    = 1'b0;
    done_s      = 1'b0;
    if ((state_r != IDLE) && trigger) begin
      state_nxt_s = IDLE;
      pileup_s    = 1'b1;
    end else if ((state_r != IDLE) && end_impuls) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (trig_ok_s) state_nxt_s = RUN;
          else           state_nxt_s = IDLE;
        end
        RUN: begin
          if (cnt_r == run_end_s) state_nxt_s = FLAT;
          else                    state_nxt_s = RUN;
        end
        FLAT: begin
          if (cnt_r == flat_end_s) state_nxt_s = TAIL;
          else                     state_nxt_s = FLAT;
        end
        TAIL: begin
          if (cnt_r == tail_end_s) begin
            state_nxt_s = IDLE;
            done_s      = 1'b1;
          end else begin
            state_nxt_s = TAIL;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Cycle counter since trigger (saturating) and per-pulse constant latch
  always_ff @(posedge clk or negedge reset_mult) begin
    if (!reset_mult) begin
      cnt_r   <= {CNT_W{1'b0}};
      run_k_r <= {CONST_W{1'b0}};
      run_l_r <= {CONST_W{1'b0}};
    end else if (trig_ok_s) begin
      cnt_r   <= {CNT_W{1'b0}};
      run_k_r <= k_act_s;
      run_l_r <= l_act_s;
    end else if ((state_r != IDLE) && (cnt_r != CNT_MAX)) begin
      cnt_r   <= cnt_r + CNT_ONE;
    end else begin
      cnt_r   <= cnt_r;
    end
  end

`ifdef PEAK_SEARCH_EN
  // Running signed maximum over the flat top, restarted on flat-top entry
  always_comb begin
    energy_nxt_s = energy_r;
    if ((state_r == RUN) && (state_nxt_s == FLAT)) begin
      energy_nxt_s = DATA_MIN;
    end else if ((state_r == FLAT) && (shaper_data > energy_r)) begin
      energy_nxt_s = shaper_data;
    end else begin
      energy_nxt_s = energy_r;
    end
  end
`else
  logic [CNT_W-1:0] mid_s;
  assign mid_s = PIPE_LAT_C + CNT_W'(sum_kl_s >> 1);

  // Single sample at the flat-top midpoint
  always_comb begin
    energy_nxt_s = energy_r;
    if ((state_r == FLAT) && (cnt_r == mid_s)) begin
      energy_nxt_s = shaper_data;
    end else begin
      energy_nxt_s = energy_r;
    end
  end
`endif

  // Registered outputs: window, busy, strobes and captured energy
  always_ff @(posedge clk or negedge reset_mult) begin
    if (!reset_mult) begin
      pulse_time_r   <= 1'b0;
      busy_r         <= 1'b0;
      energy_valid_r <= 1'b0;
      pileup_r       <= 1'b0;
      energy_r       <= {DATA_W{1'b0}};
    end else begin
      pulse_time_r   <= (state_nxt_s != IDLE);
      busy_r         <= (state_nxt_s != IDLE);
      energy_valid_r <= done_s;
      pileup_r       <= pileup_s;
      energy_r       <= energy_nxt_s;
    end
  end

  assign k_trapez     = k_act_s;
  assign l_trapez     = l_act_s;
  assign pulse_time   = pulse_time_r;
  assign busy         = busy_r;
  assign energy       = energy_r;
  assign energy_valid = energy_valid_r;
  assign pileup       = pileup_r;

endmodule

// File: tb/tb_trapez_pulse_sequencer.sv
// Scoreboard bench for trapez_pulse_sequencer: stimulus pushes the expected
// strobe (kind, energy, cycle) into a queue; a negedge monitor pops and
// compares each energy_valid / pileup strobe the DUT presents.
module tb_trapez_pulse_sequencer;

  logic               clk = 1'b0;
  logic               reset_mult = 1'b0;
  logic               trigger = 1'b0;
  logic               end_impuls = 1'b0;
  logic               cfg_wr = 1'b0;
  logic [15:0]        cfg_k = 16'd0, cfg_l = 16'd0, cfg_m1 = 16'd0, cfg_m2 = 16'd0;
  logic signed [15:0] shaper_data = 16'sd0;
  logic [15:0]        k_trapez, l_trapez, M1_trapez, M2_trapez;
  logic               pulse_time, busy, energy_valid, pileup, cfg_err;
  logic signed [15:0] energy;

  typedef struct {
    bit is_pile;
    int energy;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   tstart = -1000;
  int   data_mode = 0;

`ifdef PEAK_SEARCH_EN
  localparam int MODE3_ENERGY = 1200;
`else
  localparam int MODE3_ENERGY = 1000;
`endif

  trapez_pulse_sequencer #(.PIPE_LAT(6)) dut (
    .clk(clk), .reset_mult(reset_mult), .trigger(trigger), .end_impuls(end_impuls),
    .cfg_wr(cfg_wr), .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m1(cfg_m1), .cfg_m2(cfg_m2),
    .shaper_data(shaper_data), .k_trapez(k_trapez), .l_trapez(l_trapez),
    .M1_trapez(M1_trapez), .M2_trapez(M2_trapez), .pulse_time(pulse_time), .busy(busy),
    .energy(energy), .energy_valid(energy_valid), .pileup(pileup), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Shaper stand-in: value depends on cycles since trigger (== DUT cnt)
  function automatic int data_for(input int mode, input int off);
    if (off < 0 || off > 30) return 0;
    case (mode)
      1: return (off >= 10 && off <= 15) ? 1000 : off * 100;
      2: return (off >= 10 && off <= 15) ? -500 : off * 10;
      3: begin
        case (off)
          8:  return 1250;
          9:  return 900;
          10: return 1200;
          11: return 1000;
          12: return 1100;
          13: return 950;
          14: return 1300;
          default: return 0;
        endcase
      end
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) shaper_data = 16'(data_for(data_mode, cyc - tstart));

  // Monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (reset_mult && (energy_valid || pileup)) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_strobe: energy_valid=%0b pileup=%0b cyc=%0d, required none",
                 energy_valid, pileup, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ((energy_valid != !mon_e.is_pile) || (pileup != mon_e.is_pile) ||
            (cyc != mon_e.cyc) || (!mon_e.is_pile && int'(energy) != mon_e.energy)) begin
          failures = failures + 1;
          $display("FAIL strobe: got ev=%0b pile=%0b energy=%0d cyc=%0d, required pile=%0b energy=%0d cyc=%0d",
                   energy_valid, pileup, energy, cyc, mon_e.is_pile, mon_e.energy, mon_e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input longint act, input longint req);
    checks = checks + 1;
    if (act != req) begin
      failures = failures + 1;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic do_cfg(input int k, input int l, input int m1, input int m2);
    cfg_k = 16'(k); cfg_l = 16'(l); cfg_m1 = 16'(m1); cfg_m2 = 16'(m2);
    cfg_wr = 1'b1;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  task automatic push(input bit is_pile, input int e, input int at);
    exp_t x;
    x.is_pile = is_pile; x.energy = e; x.cyc = at;
    exp_q.push_back(x);
  endtask

  // Trigger pulse; on return cyc == tstart and DUT cnt == 0
  task automatic start_pulse(input int mode);
    data_mode = mode;
    tstart    = cyc + 1;
    trigger   = 1'b1;
    tick(1);
    trigger   = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_pulse_time", pulse_time, 0);
    check("rst_k", k_trapez, 0);
    check("rst_energy", energy, 0);
    check("rst_cfg_err", cfg_err, 0);
    reset_mult = 1'b1;
    tick(1);

    // Trigger before any configuration is ignored
    trigger = 1'b1; tick(1); trigger = 1'b0;
    check("unconfigured_trigger_busy", busy, 0);

    // Test 1: k=4, l=10 -> strobe 20 cycles after trigger edge, energy 1000
    do_cfg(4, 10, 7, 9);
    check("cfg1_k", k_trapez, 4);
    check("cfg1_l", l_trapez, 10);
    check("cfg1_m1", M1_trapez, 7);
    check("cfg1_m2", M2_trapez, 9);
    check("cfg1_err", cfg_err, 0);
    push(1'b0, 1000, cyc + 1 + 20);
    start_pulse(1);
    check("t1_pulse_time", pulse_time, 1);
    check("t1_busy", busy, 1);
    tick(25);
    check("t1_idle", busy, 0);

    // Test 2: legality checks and boundaries
    do_cfg(10, 5, 1, 1);
    check("t2_illegal_err", cfg_err, 1);
    check("t2_illegal_k_kept", k_trapez, 4);
    do_cfg(3, 8, 1, 1);
    check("t2_legal_err", cfg_err, 0);
    check("t2_legal_k", k_trapez, 3);
    do_cfg(30, 31, 1, 1);
    check("t2_sum61_err", cfg_err, 1);
    check("t2_sum61_k_kept", k_trapez, 3);
    do_cfg(5, 5, 1, 1);
    check("t2_l_eq_k_err", cfg_err, 1);
    do_cfg(29, 31, 1, 1);
    check("t2_sum60_err", cfg_err, 0);
    check("t2_sum60_k", k_trapez, 29);
    do_cfg(0, 5, 1, 1);
    check("t2_k0_err", cfg_err, 1);
    do_cfg(4, 10, 7, 9);
    check("t2_restore_k", k_trapez, 4);

    // Test 3: cfg_wr ignored when busy; second trigger at cnt 8 -> pile-up
    start_pulse(1);
    tick(5);
    cfg_k = 16'd5; cfg_l = 16'd9; cfg_wr = 1'b1;
    tick(1);
    cfg_wr = 1'b0;
    check("t3_busy_cfg_k_kept", k_trapez, 4);
    check("t3_busy_cfg_no_err", cfg_err, 0);
    tick(2);
    trigger = 1'b1;
    push(1'b1, 0, cyc + 1);
    tick(1);
    trigger = 1'b0;
    check("t3_busy_after_pile", busy, 0);
    check("t3_pulse_after_pile", pulse_time, 0);
    tick(30);

    // Test 4: end_impuls at cnt 12 aborts silently
    start_pulse(1);
    tick(12);
    end_impuls = 1'b1;
    tick(1);
    end_impuls = 1'b0;
    check("t4_busy_after_abort", busy, 0);
    check("t4_pulse_after_abort", pulse_time, 0);
    tick(25);

    // trigger + cfg_wr together: pulse timed with old k=4,l=10, new k visible
    cfg_k = 16'd3; cfg_l = 16'd8; cfg_m1 = 16'd2; cfg_m2 = 16'd3; cfg_wr = 1'b1;
    push(1'b0, -500, cyc + 1 + 20);
    start_pulse(2);
    cfg_wr = 1'b0;
    check("t4_new_k_applied", k_trapez, 3);
    tick(25);

    // Test 6: k=3,l=8 flat top cnt 9..13, midpoint cnt 11
    push(1'b0, MODE3_ENERGY, cyc + 1 + 17);
    start_pulse(3);
    tick(22);

    // end_impuls and trigger together: pile-up wins
    start_pulse(1);
    tick(5);
    trigger = 1'b1; end_impuls = 1'b1;
    push(1'b1, 0, cyc + 1);
    tick(1);
    trigger = 1'b0; end_impuls = 1'b0;
    check("both_busy", busy, 0);
    tick(25);

    // Test 5: asynchronous reset mid flat top
    start_pulse(3);
    tick(10);
    reset_mult = 1'b0;
    #1;
    check("t5_async_busy", busy, 0);
    check("t5_async_pulse_time", pulse_time, 0);
    check("t5_async_k", k_trapez, 0);
    check("t5_async_energy", energy, 0);
    tick(2);
    reset_mult = 1'b1;
    tick(1);
    trigger = 1'b1; tick(1); trigger = 1'b0;
    check("t5_trigger_ignored", busy, 0);
    do_cfg(4, 10, 7, 9);
    push(1'b0, 1000, cyc + 1 + 20);
    start_pulse(1);
    tick(20);

    // Drain: bounded wait for every expected strobe
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
    check("scoreboard_drained", exp_q.size(), 0);
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
